// File: rtl/mac_accumulator_pkg.sv
// Shared definitions for the MAC compute stage and the control unit that feeds it:
// default geometry, accumulator width derivation and FSM state encoding.
package mac_accumulator_pkg;

    localparam int MAC_DATA_WIDTH = 8;
    localparam int MAC_BRAM_DEPTH = 2;
    localparam int MAC_ADDR_WIDTH = 2;

    // Wide enough to sum 2**ADDR_WIDTH full-scale signed products without overflow.
    function automatic int acc_width_f(input int data_width, input int addr_width);
        return 2 * data_width + addr_width;
    endfunction

    localparam int MAC_ACC_WIDTH = acc_width_f(MAC_DATA_WIDTH, MAC_ADDR_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// Control-unit facing bus of the MAC stage: operand writes, start request and
// the valid/ready result port.
interface mac_accumulator_if
    import mac_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = MAC_DATA_WIDTH,
    parameter int ADDR_WIDTH = MAC_ADDR_WIDTH,
    parameter int ACC_WIDTH  = acc_width_f(DATA_WIDTH, ADDR_WIDTH)
);

    logic                         enable_cu;
    logic                         write_mode;
    logic [ADDR_WIDTH-1:0]        address;
    logic                         compute_ready;
    logic signed [DATA_WIDTH-1:0] a_in;
    logic signed [DATA_WIDTH-1:0] b_in;
    logic                         busy;
    logic signed [ACC_WIDTH-1:0]  result;
    logic                         result_valid;
    logic                         result_ready;

    modport master (
        output enable_cu, write_mode, address, compute_ready, a_in, b_in, result_ready,
        input  busy, result, result_valid
    );

    modport slave (
        input  enable_cu, write_mode, address, compute_ready, a_in, b_in, result_ready,
        output busy, result, result_valid
    );

endinterface

// File: rtl/mac_accumulator_operand_bram.sv
// Operand pair storage: one write port, one registered read port, storage array
// deliberately left without reset so contents survive a reset.
module mac_accumulator_operand_bram #(
    parameter int DATA_WIDTH = 8,
    parameter int BRAM_DEPTH = 2,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [2*DATA_WIDTH-1:0]   wr_data,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [2*DATA_WIDTH-1:0]   rd_data
);

    logic [2*DATA_WIDTH-1:0] mem_r [BRAM_DEPTH];
    logic [2*DATA_WIDTH-1:0] rd_mux_s;
    logic [2*DATA_WIDTH-1:0] rd_data_r;

    // Storage array write; out-of-range addresses match no slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BRAM_DEPTH; i++) begin
            if (wr_en && (wr_addr == ADDR_WIDTH'(i))) begin
                mem_r[i] <= wr_data;
            end
        end
    end

    // Read-side slot select.
    always_comb begin
        rd_mux_s = {(2*DATA_WIDTH){1'b0}};
        for (int i = 0; i < BRAM_DEPTH; i++) begin
            rd_mux_s = (rd_addr == ADDR_WIDTH'(i)) ? mem_r[i] : rd_mux_s;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_r <= {(2*DATA_WIDTH){1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_mux_s;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/mac_accumulator.sv
// Signed dot-product engine: loads operand pairs while idle, then walks the buffer
// on a start request and hands the sum out through a valid/ready port.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = MAC_DATA_WIDTH,
    parameter int BRAM_DEPTH = MAC_BRAM_DEPTH,
    parameter int ADDR_WIDTH = MAC_ADDR_WIDTH,
    parameter int ACC_WIDTH  = acc_width_f(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    mac_accumulator_if.slave bus
);

    // One extra pointer bit so the pointer can reach BRAM_DEPTH == 2**ADDR_WIDTH.
    localparam int PTR_WIDTH = ADDR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(BRAM_DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    state_t                       state_r, state_next_s;
    logic signed [ACC_WIDTH-1:0]  acc_r, acc_next_s;
    logic signed [ACC_WIDTH-1:0]  result_r, result_next_s;
    logic [PTR_WIDTH-1:0]         rd_ptr_r, rd_ptr_next_s;
    logic                         op_valid_r, op_valid_next_s;
    logic                         busy_r;
    logic                         result_valid_r;
    logic                         wr_en_s;
    logic                         rd_en_s;
    logic [2*DATA_WIDTH-1:0]      rd_data_s;
    logic signed [DATA_WIDTH-1:0] a_op_s;
    logic signed [DATA_WIDTH-1:0] b_op_s;
    logic signed [ACC_WIDTH-1:0]  prod_s;

    assign wr_en_s = (state_r == IDLE) && bus.enable_cu && bus.write_mode
                     && ({1'b0, bus.address} < DEPTH_P);

    mac_accumulator_operand_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .BRAM_DEPTH (BRAM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_operand_bram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_addr (bus.address),
        .wr_data ({bus.a_in, bus.b_in}),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r[ADDR_WIDTH-1:0]),
        .rd_data (rd_data_s)
    );

    assign a_op_s = $signed(rd_data_s[2*DATA_WIDTH-1:DATA_WIDTH]);
    assign b_op_s = $signed(rd_data_s[DATA_WIDTH-1:0]);
    assign prod_s = ACC_WIDTH'(a_op_s) * ACC_WIDTH'(b_op_s);

    // Next-state and datapath update; the read of slot k overlaps the add of slot k-1.
    always_comb begin
        state_next_s    = state_r;
        acc_next_s      = acc_r;
        rd_ptr_next_s   = rd_ptr_r;
        op_valid_next_s = op_valid_r;
        result_next_s   = result_r;
        rd_en_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.compute_ready) begin
                    state_next_s    = COMPUTE;
                    acc_next_s      = {ACC_WIDTH{1'b0}};
                    rd_ptr_next_s   = {PTR_WIDTH{1'b0}};
                    op_valid_next_s = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COMPUTE: begin
                if (op_valid_r) begin
                    acc_next_s = acc_r + prod_s;
                end else begin
                    acc_next_s = acc_r;
                end
                if (rd_ptr_r < DEPTH_P) begin
                    rd_en_s         = 1'b1;
                    rd_ptr_next_s   = rd_ptr_r + PTR_ONE;
                    op_valid_next_s = 1'b1;
                end else begin
                    state_next_s    = DONE;
                    result_next_s   = acc_r + prod_s;
                    op_valid_next_s = 1'b0;
                end
            end
            DONE: begin
                if (result_valid_r && bus.result_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered output flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r          <= {ACC_WIDTH{1'b0}};
            result_r       <= {ACC_WIDTH{1'b0}};
            rd_ptr_r       <= {PTR_WIDTH{1'b0}};
            op_valid_r     <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            acc_r          <= acc_next_s;
            result_r       <= result_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            op_valid_r     <= op_valid_next_s;
            busy_r         <= (state_next_s != IDLE);
            result_valid_r <= (state_next_s == DONE);
        end
    end

    assign bus.busy         = busy_r;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;

endmodule
